fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the 16-bit core. Directly upstream of the PC/SP immediate ALU.
- Owns the architectural PC and fetches one 16-bit instruction word at a time from instruction memory over a req/ack + response handshake.
- Presents instruction and its PC to decode/ALU with a valid/ready handshake.
- Accepts PC redirects (CHGPCI result, branches) from downstream.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset (bit 0 must be 0)
PC_STEP, 2, byte increment between sequential instructions

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
memReq  output  1  instruction read request
memAddr  output  16  read address; valid while memReq=1
memAck  input  1  memory accepted request this cycle
memValid  input  1  read data valid this cycle
memData  input  16  read data
instrValid  output  1  instrOut/pcOut hold an instruction for downstream
instrReady  input  1  downstream accepts instruction this cycle
instrOut  output  16  fetched instruction word
pcOut  output  16  address instrOut was fetched from (feeds ALU pcIn)
redirectValid  input  1  downstream requests PC change
redirectPc  input  16  new PC; bit 0 ignored (forced 0)

Behaviour:
- Reset (async, rst=1): state=S_REQ, fetchPc=RESET_PC, squash=0, instrValid=0, instrOut=0, pcOut=0. memReq=1 in the first clock edge after rst deasserts.
- At most one memory transaction outstanding. Memory response arrives ≥1 cycle after memAck, in order.
- memReq=1 only in S_REQ. memAddr=fetchPc, driven 0 outside S_REQ. instrValid=1 only in S_HOLD.
- S_REQ:
  - memAck=1 → S_WAIT.
  - No ack → stay; memAddr may change only via redirect.
- S_WAIT, on memValid:
  - squash=1: discard data, clear squash → S_REQ.
  - Otherwise: instrOut←memData, pcOut←fetchPc, fetchPc←fetchPc+PC_STEP (mod 2^16, 16'hFFFE wraps to 16'h0000) → S_HOLD.
- S_HOLD: outputs stable while instrReady=0. instrValid&instrReady → S_REQ next cycle (transfer complete).
- Redirect (any state, redirectValid=1): fetchPc←{redirectPc[15:1],1'b0} next edge; it overrides the sequential increment.
  - S_REQ, no memAck: stay in S_REQ; new address is presented next cycle.
  - S_REQ with memAck same cycle: → S_WAIT, squash=1 (the old-address response is dropped).
  - S_WAIT without memValid: squash←1.
  - S_WAIT with memValid same cycle: drop data → S_REQ, squash stays 0.
  - S_HOLD: instrValid drops next cycle → S_REQ. If instrReady=1 in the same cycle, the transfer still counts as completed.
- Multiple redirects while squashed: last one wins; squash stays 1 until one response is dropped.
- Mid-transaction reset: everything returns to reset values immediately. The memory side shares rst, so no stale response is expected.
- Best-case throughput: 1 instruction per 3 cycles (REQ, WAIT, HOLD). This is acceptable for the single-cycle-issue legacy core.

Test Plan:
- Reset release, memAck in same cycle, memValid next cycle with memData=16'h1234, instrReady=1 → memAddr=16'h0000, then instrValid=1, instrOut=16'h1234, pcOut=16'h0000; next memAddr=16'h0002.
- Hold instrReady=0 for 5 cycles in S_HOLD → instrValid, instrOut, pcOut unchanged; memReq=0 throughout; release → next memReq at addr +2.
- Redirect redirectPc=16'h0041 while in S_WAIT, response 16'hDEAD arrives two cycles later → 16'hDEAD never shown; next memAddr=16'h0040; instruction at 0x0040 emerges with pcOut=16'h0040.
- redirectValid and memAck same cycle at fetchPc=16'h0010, redirectPc=16'h0100 → following response squashed; next request at 16'h0100.
- fetchPc=16'hFFFE, fetch completes → pcOut=16'hFFFE; next memAddr=16'h0000.
- Assert rst while in S_WAIT → instrValid=0, memReq=0 while rst=1; memReq=1 with memAddr=RESET_PC on the first edge after release.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: owns the PC, fetches one 16-bit word per memory transaction
// Single outstanding request; redirects squash any in-flight response from the old address.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        memReq,
  output logic [15:0] memAddr,
  input  logic        memAck,
  input  logic        memValid,
  input  logic [15:0] memData,
  output logic        instrValid,
  input  logic        instrReady,
  output logic [15:0] instrOut,
  output logic [15:0] pcOut,
  input  logic        redirectValid,
  input  logic [15:0] redirectPc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_fetch_pc;
  logic [15:0] w_next_pc;
  logic        r_squash;
  logic        w_next_squash;
  logic        w_capture;
  logic [15:0] r_instr;
  logic [15:0] r_pc;
  logic [15:0] w_redirect_pc;

  assign w_redirect_pc = redirectPc & 16'hFFFE;

  always_comb begin
    w_next_state  = r_state;
    w_next_pc     = redirectValid ? w_redirect_pc : r_fetch_pc;
    w_next_squash = r_squash;
    w_capture     = 1'b0;
    case (r_state)
      S_REQ: begin
        if (memAck) begin
          w_next_state  = S_WAIT;
          w_next_squash = redirectValid;
        end
      end
      S_WAIT: begin
        if (memValid) begin
          w_next_state  = S_REQ;
          w_next_squash = 1'b0;
          // A redirect landing on the response cycle drops the data just like a pending squash.
          if (!r_squash && !redirectValid) begin
            w_next_state = S_HOLD;
            w_capture    = 1'b1;
            w_next_pc    = r_fetch_pc + PC_STEP;
          end
        end else if (redirectValid) begin
          w_next_squash = 1'b1;
        end
      end
      S_HOLD: begin
        if (instrReady || redirectValid) begin
          w_next_state = S_REQ;
        end
      end
      default: begin
        w_next_state = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC & 16'hFFFE;
      r_squash   <= 1'b0;
      r_instr    <= 16'h0000;
      r_pc       <= 16'h0000;
    end else begin
      r_state    <= w_next_state;
      r_fetch_pc <= w_next_pc;
      r_squash   <= w_next_squash;
      if (w_capture) begin
        r_instr <= memData;
        r_pc    <= r_fetch_pc;
      end
    end
  end

  assign memReq     = (r_state == S_REQ) && !rst;
  assign memAddr    = memReq ? r_fetch_pc : 16'h0000;
  assign instrValid = (r_state == S_HOLD);
  assign instrOut   = r_instr;
  assign pcOut      = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized checks of fetch_unit against a transaction-level model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memAck;
  logic        memValid;
  logic [15:0] memData;
  logic        instrValid;
  logic        instrReady;
  logic [15:0] instrOut;
  logic [15:0] pcOut;
  logic        redirectValid;
  logic [15:0] redirectPc;

  int total = 0;
  int bad   = 0;

  fetch_unit #(.RESET_PC(16'h0000), .PC_STEP(16'd2)) dut (
    .clk(clk), .rst(rst),
    .memReq(memReq), .memAddr(memAddr), .memAck(memAck),
    .memValid(memValid), .memData(memData),
    .instrValid(instrValid), .instrReady(instrReady),
    .instrOut(instrOut), .pcOut(pcOut),
    .redirectValid(redirectValid), .redirectPc(redirectPc)
  );

  always #5 clk = ~clk;

  // Transaction model: next fetch address, one in-flight read (maybe stale), one held instruction.
  logic [15:0] m_pc;
  bit          m_busy;
  bit          m_stale;
  logic [15:0] m_addr;
  bit          m_hold;
  logic [15:0] m_hdata;
  logic [15:0] m_hpc;

  task automatic model_reset();
    m_pc = 16'h0000; m_busy = 0; m_stale = 0; m_addr = 16'h0000;
    m_hold = 0; m_hdata = 16'h0000; m_hpc = 16'h0000;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit req;
    req = !m_busy && !m_hold;
    chk("memReq", {15'd0, memReq}, {15'd0, req});
    chk("memAddr", memAddr, req ? m_pc : 16'h0000);
    chk("instrValid", {15'd0, instrValid}, {15'd0, m_hold});
    if (m_hold) begin
      chk("instrOut", instrOut, m_hdata);
      chk("pcOut", pcOut, m_hpc);
    end
  endtask

  task automatic model_update();
    bit req;
    bit was_hold;
    logic [15:0] npc;
    req      = !m_busy && !m_hold;
    was_hold = m_hold;
    npc      = m_pc;
    if (was_hold && (instrReady || redirectValid)) m_hold = 0;
    if (m_busy && memValid) begin
      if (!m_stale && !redirectValid) begin
        m_hold = 1; m_hdata = memData; m_hpc = m_addr; npc = m_addr + 16'd2;
      end
      m_busy = 0; m_stale = 0;
    end else if (m_busy && redirectValid) begin
      m_stale = 1;
    end
    if (req && memAck) begin
      m_busy = 1; m_addr = m_pc; m_stale = redirectValid;
    end
    if (redirectValid) npc = {redirectPc[15:1], 1'b0};
    m_pc = npc;
  endtask

  // Called just after a negedge: drive one cycle of inputs, advance the model at the edge, check outputs.
  task automatic step(input bit ack, input bit vld, input logic [15:0] data,
                      input bit rdy, input bit rv, input logic [15:0] rpc);
    memAck = ack; memValid = vld; memData = vld ? data : 16'($urandom);
    instrReady = rdy; redirectValid = rv; redirectPc = rpc;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int lat;
    bit req;
    bit a;
    bit v;
    bit r;
    bit rv;
    lat = 0;
    rst = 1'b1; memAck = 0; memValid = 0; memData = 0; instrReady = 0;
    redirectValid = 0; redirectPc = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_memReq", {15'd0, memReq}, 16'd0);
    chk("rst_instrValid", {15'd0, instrValid}, 16'd0);
    chk("rst_instrOut", instrOut, 16'h0000);
    chk("rst_pcOut", pcOut, 16'h0000);
    rst = 1'b0;
    #1;
    check_model();
    chk("first_memAddr", memAddr, 16'h0000);

    // Basic fetch
    step(1, 0, 0, 0, 0, 0);
    chk("wait_memReq", {15'd0, memReq}, 16'd0);
    step(0, 1, 16'h1234, 0, 0, 0);
    chk("d1_valid", {15'd0, instrValid}, 16'd1);
    chk("d1_instr", instrOut, 16'h1234);
    chk("d1_pc", pcOut, 16'h0000);
    step(0, 0, 0, 1, 0, 0);
    chk("d1_next_addr", memAddr, 16'h0002);

    // Stall in HOLD for 5 cycles
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 16'hBEEF, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    chk("d2_instr", instrOut, 16'hBEEF);
    chk("d2_pc", pcOut, 16'h0002);
    chk("d2_memReq", {15'd0, memReq}, 16'd0);
    step(0, 0, 0, 1, 0, 0);
    chk("d2_next_addr", memAddr, 16'h0004);

    // Redirect while waiting; stale 16'hDEAD must be dropped
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 16'h0041);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 16'hDEAD, 0, 0, 0);
    chk("d3_no_valid", {15'd0, instrValid}, 16'd0);
    chk("d3_addr", memAddr, 16'h0040);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 16'h4040, 0, 0, 0);
    chk("d3_instr", instrOut, 16'h4040);
    chk("d3_pc", pcOut, 16'h0040);
    step(0, 0, 0, 1, 0, 0);

    // Redirect coincident with memAck
    step(0, 0, 0, 0, 1, 16'h0010);
    chk("d4_addr10", memAddr, 16'h0010);
    step(1, 0, 0, 0, 1, 16'h0100);
    step(0, 1, 16'h1111, 0, 0, 0);
    chk("d4_no_valid", {15'd0, instrValid}, 16'd0);
    chk("d4_addr", memAddr, 16'h0100);

    // Wrap at 16'hFFFE
    step(0, 0, 0, 0, 1, 16'hFFFF);
    chk("d5_addr", memAddr, 16'hFFFE);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 16'h7777, 0, 0, 0);
    chk("d5_pc", pcOut, 16'hFFFE);
    step(0, 0, 0, 1, 0, 0);
    chk("d5_wrap", memAddr, 16'h0000);

    // Reset while waiting
    step(1, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("d6_rst_memReq", {15'd0, memReq}, 16'd0);
    chk("d6_rst_valid", {15'd0, instrValid}, 16'd0);
    memAck = 0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    chk("d6_memReq", {15'd0, memReq}, 16'd1);
    chk("d6_addr", memAddr, 16'h0000);
    check_model();

    // Randomized traffic with a variable-latency memory
    for (int i = 0; i < 3000; i++) begin
      req = !m_busy && !m_hold;
      a   = ($urandom % 2) == 0;
      v   = 0;
      if (m_busy) begin
        if (lat == 0) v = 1;
        else lat--;
      end
      r  = ($urandom % 2) == 0;
      rv = ($urandom % 8) == 0;
      step(a, v, 16'($urandom), r, rv, 16'($urandom));
      if (req && a) lat = $urandom_range(0, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
